// File: rtl/raster_pkg.sv
// raster_pkg: default extents and small helpers shared by the raster position generator
package raster_pkg;
  localparam int X_MAX_DEF  = 1920;
  localparam int Y_MAX_DEF  = 1080;
  localparam int LAYERS_DEF = 4;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int clamp(input int v, input int mx);
    return (v == 0 || v > mx) ? mx : v;
  endfunction
endpackage

// File: rtl/wrap_cnt.sv
// wrap_cnt: modulo-limit counter with a combinational carry on the wrapping step
module wrap_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W:0]   limit,
  output logic [W-1:0] count,
  output logic         carry
);
  assign carry = en && ({1'b0, count} == limit - 1'b1);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (en) count <= carry ? '0 : count + 1'b1;
endmodule

// File: rtl/pixel_raster_counter.sv
// pixel_raster_counter: layer-major (layer, x, y) raster walker with frame-latched extents
module pixel_raster_counter
  import raster_pkg::*;
#(
  parameter int X_MAX  = X_MAX_DEF,
  parameter int Y_MAX  = Y_MAX_DEF,
  parameter int LAYERS = LAYERS_DEF,
  parameter int X_W    = cw(X_MAX),
  parameter int Y_W    = cw(Y_MAX),
  parameter int L_W    = cw(LAYERS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pixelInc,
  input  logic           restart,
  input  logic [X_W-1:0] xActive,
  input  logic [Y_W-1:0] yActive,
  output logic [L_W-1:0] layer,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           lineStart,
  output logic           frameStart
);
  logic [X_W:0] r_x_lim;
  logic [Y_W:0] r_y_lim;
  logic         r_line_start, r_frame_start;
  logic         w_clr, w_adv, w_l_carry, w_x_carry, w_y_carry;
  assign w_clr      = reset | restart;
  assign w_adv      = pixelInc & ~w_clr;
  assign lineStart  = r_line_start;
  assign frameStart = r_frame_start;
  wrap_cnt #(.W(L_W)) u_layer (
    .clk(clk), .reset(w_clr), .en(w_adv), .limit((L_W+1)'(LAYERS)),
    .count(layer), .carry(w_l_carry)
  );
  wrap_cnt #(.W(X_W)) u_x (
    .clk(clk), .reset(w_clr), .en(w_l_carry), .limit(r_x_lim),
    .count(x), .carry(w_x_carry)
  );
  wrap_cnt #(.W(Y_W)) u_y (
    .clk(clk), .reset(w_clr), .en(w_x_carry), .limit(r_y_lim),
    .count(y), .carry(w_y_carry)
  );
  // extents reload at every frame origin so the new frame's first line already uses them
  always_ff @(posedge clk) begin
    if (w_clr || w_y_carry) begin
      r_x_lim <= (X_W+1)'(clamp(int'(xActive), X_MAX));
      r_y_lim <= (Y_W+1)'(clamp(int'(yActive), Y_MAX));
    end
    r_line_start  <= w_x_carry & ~w_y_carry;
    r_frame_start <= ~reset & (restart | w_y_carry);
  end
endmodule

// File: tb/tb_pixel_raster_counter.sv
// tb_pixel_raster_counter: directed checks of raster order, wrap pulses, extent latching and priority
module tb_pixel_raster_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b0, rs = 1'b0, inc = 1'b0;
  logic [10:0] ax = '0, ay = '0, bx = '0, by = '0;
  logic [0:0]  a_l;
  logic [10:0] a_x, a_y, b_x, b_y;
  logic [1:0]  b_l;
  logic        a_ls, a_fs, b_ls, b_fs;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  pixel_raster_counter #(.LAYERS(2)) dut_a (
    .clk(clk), .reset(rst), .pixelInc(inc), .restart(rs), .xActive(ax), .yActive(ay),
    .layer(a_l), .x(a_x), .y(a_y), .lineStart(a_ls), .frameStart(a_fs)
  );
  pixel_raster_counter dut_b (
    .clk(clk), .reset(rst), .pixelInc(inc), .restart(rs), .xActive(bx), .yActive(by),
    .layer(b_l), .x(b_x), .y(b_y), .lineStart(b_ls), .frameStart(b_fs)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h ({layer,x,y,lineStart,frameStart})", tag, obs, exp);
    end
  endtask
  task automatic chk_a(input string tag, input int l, input int xx, input int yy, input int ls, input int fs);
    cmp(tag, {7'b0, a_l, a_x, a_y, a_ls, a_fs}, {7'b0, 1'(l), 11'(xx), 11'(yy), 1'(ls), 1'(fs)});
  endtask
  task automatic chk_b(input string tag, input int l, input int xx, input int yy, input int ls, input int fs);
    cmp(tag, {6'b0, b_l, b_x, b_y, b_ls, b_fs}, {6'b0, 2'(l), 11'(xx), 11'(yy), 1'(ls), 1'(fs)});
  endtask
  // expected state of dut_a (2 layers, 3 lines, xw pixels) after k strobes from the frame origin
  task automatic exp_a(input string tag, input int k, input int xw);
    chk_a(tag, k % 2, (k / 2) % xw, (k / (2 * xw)) % 3,
          int'(k > 0 && k % (2 * xw) == 0 && k % (6 * xw) != 0),
          int'(k > 0 && k % (6 * xw) == 0));
  endtask
  initial begin
    rst = 1'b1; ax = 11'd4; ay = 11'd3; tick(); rst = 1'b0;
    chk_a("a_reset", 0, 0, 0, 0, 0);
    inc = 1'b1;
    for (int k = 1; k <= 24; k++) begin tick(); exp_a("b2b", k, 4); end
    inc = 1'b0; tick();
    chk_a("hold", 0, 0, 0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      inc = 1'b1; tick(); inc = 1'b0;
      exp_a("gap", k, 4);
      for (int g = 0; g < 3; g++) begin tick(); chk_a("gap_idle", k % 2, (k / 2) % 4, (k / 8) % 3, 0, 0); end
    end
    rst = 1'b1; tick(); rst = 1'b0;
    inc = 1'b1; repeat (15) tick(); inc = 1'b0;
    chk_a("pre_restart", 1, 3, 1, 0, 0);
    ax = 11'd2; rs = 1'b1; inc = 1'b1; tick(); rs = 1'b0; inc = 1'b0;
    chk_a("restart", 0, 0, 0, 0, 1);
    tick();
    chk_a("restart_idle", 0, 0, 0, 0, 0);
    inc = 1'b1;
    for (int k = 1; k <= 4; k++) begin tick(); exp_a("reload", k, 2); end
    inc = 1'b0;
    rst = 1'b1; ax = 11'd4; tick(); rst = 1'b0;
    inc = 1'b1; repeat (12) tick();
    chk_a("at_021", 0, 2, 1, 0, 0);
    ax = 11'd2;
    for (int k = 13; k <= 24; k++) begin tick(); exp_a("keep4", k, 4); end
    for (int k = 1; k <= 12; k++) begin tick(); exp_a("new2", k, 2); end
    repeat (5) tick();
    exp_a("pre_rst", 5, 2);
    rst = 1'b1; rs = 1'b1; tick(); rst = 1'b0; rs = 1'b0; inc = 1'b0;
    chk_a("rst_all", 0, 0, 0, 0, 0);
    bx = 11'd0; by = 11'd2000; rst = 1'b1; tick(); rst = 1'b0;
    chk_b("b_reset", 0, 0, 0, 0, 0);
    inc = 1'b1; repeat (7676) tick();
    chk_b("b_x1919", 0, 1919, 0, 0, 0);
    repeat (3) tick();
    chk_b("b_l3_x1919", 3, 1919, 0, 0, 0);
    tick();
    chk_b("b_linewrap", 0, 0, 1, 1, 0);
    inc = 1'b0; bx = 11'd1; rs = 1'b1; tick(); rs = 1'b0;
    chk_b("b_restart", 0, 0, 0, 0, 1);
    inc = 1'b1; repeat (4316) tick();
    chk_b("b_y1079", 0, 0, 1079, 1, 0);
    repeat (3) tick();
    chk_b("b_l3_y1079", 3, 0, 1079, 0, 0);
    tick();
    chk_b("b_framewrap", 0, 0, 0, 0, 1);
    inc = 1'b0; tick();
    chk_b("b_idle", 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pixel_raster_counter.md
# pixel_raster_counter

Parametrised raster position generator for the GPU engine's pixel pipeline. It advances a (layer, x, y) position once per pixel-increment strobe, in layer-major order: all layers of a pixel, then the next pixel, then the next line. Line and frame extents are runtime-programmable and are latched only at frame boundaries. It emits registered line/frame boundary pulses so the downstream compositor and framebuffer writer can sequence without their own counters.

## Interface
- X_MAX, 1920: maximum pixels per line; also the hard upper clamp for xActive.
- Y_MAX, 1080: maximum lines per frame; also the hard upper clamp for yActive.
- LAYERS, 4: layers visited per pixel; ≥1.
- X_W, $clog2(X_MAX): width of x and xActive.
- Y_W, $clog2(Y_MAX): width of y and yActive.
- L_W, max(1,$clog2(LAYERS)): width of layer.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pixelInc  in  1  advance strobe; one advance per cycle it is high.
- restart  in  1  synchronous return to frame origin; also reloads extents.
- xActive  in  X_W  requested pixels per line.
- yActive  in  Y_W  requested lines per frame.
- layer  out  L_W  current layer.
- x  out  X_W  current pixel, 0..xLim-1.
- y  out  Y_W  current line, 0..yLim-1.
- lineStart  out  1  one-cycle pulse: x wrapped to 0 and y advanced.
- frameStart  out  1  one-cycle pulse: position returned to (0,0,0).

## Operation
- Shadow extents xLim and yLim are loaded from xActive and yActive on reset, on restart, and on each frame wrap.
- Clamping: a value of 0, or a value greater than the MAX parameter, loads the MAX parameter.
- Advance order on pixelInc:
  - layer increments.
  - At layer = LAYERS-1, layer goes to 0 and x increments.
  - At x = xLim-1, x goes to 0 and y increments (line wrap).
  - At y = yLim-1, y goes to 0 (frame wrap).
- Priority: reset > restart > pixelInc.
- Reset:
  - layer, x, y = 0.
  - lineStart, frameStart = 0.
  - xLim = clamp(xActive), yLim = clamp(yActive).
- Restart:
  - Position returns to (0,0,0) and the shadow extents reload.
  - frameStart = 1 on the following cycle; lineStart = 0.
  - pixelInc in the same cycle is ignored.
- Line wrap without frame wrap: lineStart = 1 the next cycle.
- Frame wrap: frameStart = 1 and lineStart = 0 the next cycle, and the new extents take effect for the first line of the new frame.
- Mid-frame changes on xActive/yActive have no effect until the next load point.
- Degenerate sizes:
  - LAYERS = 1: layer is held at 0 and every strobe advances x.
  - xLim = 1: every x advance is a line wrap.
  - xLim = yLim = 1: every x advance is a frame wrap.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency is one cycle: pixelInc high at edge N gives the new position visible after edge N.
- lineStart and frameStart are high for exactly the one cycle following the wrapping advance, and low otherwise, including during consecutive non-wrapping strobes.
- Back-to-back pixelInc is supported at full rate, one advance per cycle.
- With pixelInc held low, all outputs hold and the pulses return to 0 after one cycle.
- Reset asserted mid-frame takes effect at the next edge regardless of pixelInc or restart.
- Full frame period = LAYERS·xLim·yLim strobes.

## Structure
- Package raster_pkg holds:
  - default X_MAX, Y_MAX and LAYERS constants;
  - the clamp function (0 or >MAX → MAX);
  - a width helper that returns max(1,$clog2(n)).
- Sub-module wrap_cnt is instantiated three times (layer, x, y).
  - Inputs: clk, reset, en, limit.
  - Outputs: count, carry; carry is combinational and equals en && count == limit-1.
  - Carries are chained en → layer → x → y.
- The top level holds the shadow-extent registers, the priority logic and the pulse registers.

## Test plan
- Reset with xActive=4, yActive=3, LAYERS=2, then 24 consecutive strobes:
  - sequence (l,x,y) = (0,0,0), (1,0,0), (0,1,0), …, (1,3,2) → (0,0,0);
  - lineStart pulses after strobes 8 and 16;
  - frameStart pulses after strobe 24.
- xActive=0 and yActive=2000 with default parameters → xLim = 1920, yLim = 1080.
  - Verify wrap at x = 1919 (11-bit boundary).
- Change xActive from 4 to 2 at position (0,2,1) → the current frame keeps 4 pixels per line; after the frame wrap, lines wrap at x = 1.
- restart and pixelInc together at (1,3,1) → next cycle (0,0,0) with frameStart = 1 and lineStart = 0.
- reset, restart and pixelInc together mid-frame → (0,0,0) with both pulses 0.
- pixelInc gapped 1-on/3-off → position and pulse timing identical to the back-to-back case, with pulses one cycle wide.
